matmul_cmd_ctrl: RTL and testbench
==================================

Name: matmul_cmd_ctrl

Overview:
- Command-level controller in front of the 5x5 int8 matrix multiplier unit (start/done pulse handshake, 200-bit packed operands, 200-bit result, overflow flag).
- Holds operand registers A and B and result register R, and sequences the multiplier for each compute command.
- Returns exactly one response per command.
- Sits between the host command interface (valid/ready) and the multiplier instance.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT for mul_done before the op is aborted with an error.
- FLUSH_CYCLES, 32: post-reset quiet period; must be at least the multiplier's worst-case op latency (about 29 cycles).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts command this cycle.
- cmd_op  in  3  opcode.
- cmd_data  in  200  packed matrix, element (r,c) at bits [(r*5+c)*8 +: 8].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host consumes response.
- rsp_data  out  200  response matrix.
- rsp_ovf  out  1  overflow flag for the response.
- rsp_err  out  1  error flag for the response.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  200  multiplier operand A.
- mul_b  out  200  multiplier operand B.
- mul_result  in  200  multiplier result.
- mul_done  in  1  multiplier done pulse.
- mul_overflow  in  1  multiplier overflow, valid with mul_done.
- busy  out  1  state != IDLE.
- ovf_sticky  out  1  set by any overflowing compute op; cleared only by CLR or reset.

Behaviour:
- Reset (rst_n low, async):
  - State = FLUSH. A, B, R, R_ovf, timer, ovf_sticky, rsp_* and mul_start all cleared.
  - cmd_ready = 0, busy = 1.
- States: FLUSH, IDLE, ISSUE, WAIT, RESP.
- FLUSH:
  - Counts FLUSH_CYCLES clocks after rst_n release, then goes to IDLE.
  - mul_done is ignored. This drains a multiplier op left running across a reset (the multiplier has no reset).
- IDLE:
  - cmd_ready = 1 here only. A command is accepted on cmd_valid && cmd_ready.
- Opcodes:
  - 0 NOP: go to RESP; rsp_data = 0.
  - 1 LOAD_A: A <= cmd_data in the accept cycle; go to RESP.
  - 2 LOAD_B: B <= cmd_data in the accept cycle; go to RESP.
  - 3 MUL: mul_a = A, mul_b = B; go to ISSUE.
  - 4 SQR: mul_a = A, mul_b = A; go to ISSUE. The operand select is latched at accept.
  - 5 READ_R: go to RESP; rsp_data = R, rsp_ovf = R_ovf.
  - 6 CLR: ovf_sticky <= 0 and R_ovf <= 0; go to RESP.
  - 7: go to RESP with rsp_err = 1; no register changes.
- ISSUE: mul_start = 1 for exactly this cycle; timer <= 0; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On mul_done: R <= mul_result, R_ovf <= mul_overflow, ovf_sticky |= mul_overflow. Response carries rsp_data = mul_result, rsp_ovf = mul_overflow, rsp_err = 0. Go to RESP.
  - If timer == TIMEOUT_CYCLES-1 without mul_done: R unchanged, rsp_err = 1, rsp_data = 0; go to RESP.
  - mul_done and timeout in the same cycle: done wins.
- mul_a and mul_b are driven from registers and stay stable from ISSUE through WAIT. A and B cannot change while busy.
- mul_done in any state other than WAIT is ignored. This includes a late done after a timeout.
- RESP:
  - rsp_valid = 1. rsp_data, rsp_ovf and rsp_err stay stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid drops next cycle, state goes to IDLE, and rsp_data/ovf/err return to 0.
- Response fields default to 0 unless the opcode above sets them.
- Latency:
  - LOAD, NOP, READ, CLR: rsp_valid 1 cycle after accept.
  - MUL, SQR: mul_start 1 cycle after accept; rsp_valid 1 cycle after mul_done is sampled.
  - Minimum back-to-back period is 2 cycles (accept, RESP with rsp_ready high).
- Reset mid-operation: abort immediately; mul_start and rsp_valid are forced to 0 and FLUSH restarts.

Test Plan:
- Reset, then check the flush window: cmd_ready = 0 for exactly 32 cycles after rst_n rises, then 1. A mul_done pulse injected at cycle 10 changes nothing.
- LOAD_A identity, LOAD_B with all elements 3, MUL:
  - mul_start is a single 1-cycle pulse; mul_b = B.
  - Model the multiplier with done 29 cycles later; rsp_data = all 3s, rsp_ovf = 0, rsp_err = 0.
  - READ_R then returns the same matrix.
- LOAD_A all 20, SQR with model overflow = 1:
  - mul_a = mul_b = A; rsp_ovf = 1; ovf_sticky = 1.
  - CLR clears ovf_sticky; the following READ_R returns rsp_ovf = 0.
- MUL with the model never raising done:
  - rsp_err = 1 exactly 64 cycles after the WAIT entry cycle; R is unchanged.
  - A late mul_done pulse afterwards is ignored.
- Hold rsp_ready low for 10 cycles with cmd_valid held high:
  - rsp_* stay stable and cmd_ready stays 0.
  - After the handshake, the next command is accepted 1 cycle later.
- Opcode 7 gives rsp_err = 1 with A, B, R unchanged.
- Assert rst_n low during WAIT: outputs clear asynchronously and the flush repeats.

Source files
------------

// File: rtl/matmul_cmd_ctrl.sv
// Command controller for the 5x5 int8 matrix multiplier: holds operands A/B and
// result R, sequences one multiplier op per compute command and returns exactly
// one response per accepted command.
module matmul_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned FLUSH_CYCLES   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [199:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [199:0] rsp_data,
  output logic         rsp_ovf,
  output logic         rsp_err,
  output logic         mul_start,
  output logic [199:0] mul_a,
  output logic [199:0] mul_b,
  input  logic [199:0] mul_result,
  input  logic         mul_done,
  input  logic         mul_overflow,
  output logic         busy,
  output logic         ovf_sticky
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
  localparam int unsigned TW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD_A = 3'd1,
    OP_LOAD_B = 3'd2,
    OP_MUL    = 3'd3,
    OP_SQR    = 3'd4,
    OP_READ_R = 3'd5,
    OP_CLR    = 3'd6,
    OP_BAD    = 3'd7
  } op_e;

  state_e         state_q, state_d;
  logic [199:0]   a_q, a_d;
  logic [199:0]   b_q, b_d;
  logic [199:0]   r_q, r_d;
  logic           r_ovf_q, r_ovf_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           ovf_sticky_q, ovf_sticky_d;
  logic           sel_sqr_q, sel_sqr_d;
  logic [199:0]   rsp_data_q, rsp_data_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_err_q, rsp_err_d;
  op_e            op;

  assign op = op_e'(cmd_op);

  // Handshake and strobe outputs are pure state decodes, so an async reset
  // into FLUSH clears them immediately.
  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign mul_start  = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign mul_a      = a_q;
  assign mul_b      = sel_sqr_q ? a_q : b_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign ovf_sticky = ovf_sticky_q;

  // Next-state, register updates and response capture.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    r_d          = r_q;
    r_ovf_d      = r_ovf_q;
    timer_d      = timer_q;
    ovf_sticky_d = ovf_sticky_q;
    sel_sqr_d    = sel_sqr_q;
    rsp_data_d   = rsp_data_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_FLUSH: begin
        // Quiet period lets a multiplier op started before reset drain out.
        if (timer_q == TW'(FLUSH_CYCLES - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b0;
          case (op)
            OP_NOP:    ;
            OP_LOAD_A: a_d = cmd_data;
            OP_LOAD_B: b_d = cmd_data;
            OP_MUL: begin
              sel_sqr_d = 1'b0;
              state_d   = S_ISSUE;
            end
            OP_SQR: begin
              sel_sqr_d = 1'b1;
              state_d   = S_ISSUE;
            end
            OP_READ_R: begin
              rsp_data_d = r_q;
              rsp_ovf_d  = r_ovf_q;
            end
            OP_CLR: begin
              ovf_sticky_d = 1'b0;
              r_ovf_d      = 1'b0;
            end
            default:   rsp_err_d = 1'b1;
          endcase
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done is checked before the timeout so a coincident done still wins.
        if (mul_done) begin
          r_d          = mul_result;
          r_ovf_d      = mul_overflow;
          ovf_sticky_d = ovf_sticky_q | mul_overflow;
          rsp_data_d   = mul_result;
          rsp_ovf_d    = mul_overflow;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          rsp_data_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FLUSH;
      a_q          <= '0;
      b_q          <= '0;
      r_q          <= '0;
      r_ovf_q      <= 1'b0;
      timer_q      <= '0;
      ovf_sticky_q <= 1'b0;
      sel_sqr_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      r_q          <= r_d;
      r_ovf_q      <= r_ovf_d;
      timer_q      <= timer_d;
      ovf_sticky_q <= ovf_sticky_d;
      sel_sqr_q    <= sel_sqr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_matmul_cmd_ctrl.sv
// Bench for matmul_cmd_ctrl: transaction-level model of the command set plus a
// bench-side saturating 5x5 int8 multiplier, compared against the DUT each cycle.
module tb_matmul_cmd_ctrl;

  localparam int TO = 64;
  localparam int FL = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [199:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [199:0] rsp_data;
  logic         rsp_ovf;
  logic         rsp_err;
  logic         mul_start;
  logic [199:0] mul_a;
  logic [199:0] mul_b;
  logic [199:0] mul_result;
  logic         mul_done;
  logic         mul_overflow;
  logic         busy;
  logic         ovf_sticky;

  matmul_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .FLUSH_CYCLES(FL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_done(mul_done), .mul_overflow(mul_overflow),
    .busy(busy), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state.
  logic [199:0] m_a, m_b, m_r;
  logic         m_rovf, m_sticky;

  // Expected observable outputs for the current cycle.
  bit           chk_en = 1'b0;
  logic         exp_ready, exp_busy, exp_rv, exp_start, exp_mact;
  logic [199:0] exp_rd, exp_ma, exp_mb;
  logic         exp_ro, exp_re;

  // Last response consumed by the host.
  logic [199:0] last_data;
  logic         last_ovf, last_err;

  logic [199:0] id_m, all3, all20, all127;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [199:0] rnd200();
    logic [199:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[167:0], $urandom()};
    return r;
  endfunction

  function automatic logic [199:0] small200();
    logic [199:0] r;
    logic [7:0]   e;
    r = '0;
    for (int i = 0; i < 25; i++) begin
      e = 8'($urandom_range(0, 6)) - 8'd3;
      r[i*8 +: 8] = e;
    end
    return r;
  endfunction

  // Saturating signed int8 matrix product; overflow if any element clips.
  function automatic void mmul(input logic [199:0] a, input logic [199:0] b,
                               output logic [199:0] p, output logic ovf);
    int s;
    p   = '0;
    ovf = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        s = 0;
        for (int k = 0; k < 5; k++)
          s += int'($signed(a[(r*5+k)*8 +: 8])) * int'($signed(b[(k*5+c)*8 +: 8]));
        if (s > 127) begin s = 127; ovf = 1'b1; end
        else if (s < -128) begin s = -128; ovf = 1'b1; end
        p[(r*5+c)*8 +: 8] = s[7:0];
      end
    end
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_b("cmd_ready", cmd_ready, exp_ready);
      chk_b("rsp_valid", rsp_valid, exp_rv);
      chk_b("mul_start", mul_start, exp_start);
      chk_b("busy", busy, exp_busy);
      chk_b("ovf_sticky", ovf_sticky, m_sticky);
      if (exp_rv) begin
        chk("rsp_data", rsp_data, exp_rd);
        chk_b("rsp_ovf", rsp_ovf, exp_ro);
        chk_b("rsp_err", rsp_err, exp_re);
      end else begin
        chk("rsp_data_idle", rsp_data, '0);
        chk_b("rsp_ovf_idle", rsp_ovf, 1'b0);
        chk_b("rsp_err_idle", rsp_err, 1'b0);
      end
      if (exp_mact) begin
        chk("mul_a", mul_a, exp_ma);
        chk("mul_b", mul_b, exp_mb);
      end
      if (rsp_valid && rsp_ready) begin
        last_data = rsp_data;
        last_ovf  = rsp_ovf;
        last_err  = rsp_err;
      end
    end
  end

  // Reset, then run the flush window with a stray mul_done in cycle 10.
  task automatic do_reset(input bit hand);
    int n;
    rst_n     = 1'b0;
    exp_ready = 1'b0; exp_busy = 1'b1; exp_rv = 1'b0; exp_start = 1'b0; exp_mact = 1'b0;
    exp_rd    = '0; exp_ro = 1'b0; exp_re = 1'b0;
    m_a = '0; m_b = '0; m_r = '0; m_rovf = 1'b0; m_sticky = 1'b0;
    cmd_valid = 1'b0; rsp_ready = 1'b0; mul_done = 1'b0;
    chk_en    = 1'b1;
    #1;
    if (hand) begin
      chk_b("rst_busy", busy, 1'b1);
      chk_b("rst_ready", cmd_ready, 1'b0);
      chk_b("rst_rsp_valid", rsp_valid, 1'b0);
      chk_b("rst_mul_start", mul_start, 1'b0);
      chk_b("rst_sticky", ovf_sticky, 1'b0);
      chk("rst_mul_a", mul_a, '0);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < FL; i++) begin
      if (!cmd_ready) n++;
      mul_done = (i == 9);
      if (i == 9) begin
        mul_result   = rnd200();
        mul_overflow = 1'b1;
      end
      @(posedge clk); #1;
      mul_done     = 1'b0;
      mul_overflow = 1'b0;
    end
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
    chk_i("flush_len", n, 32);
  endtask

  // One full command: accept, optional multiplier op, response with host stall.
  // done_t: WAIT cycle index in which the bench multiplier pulses done (<0 = never).
  task automatic do_cmd(input logic [2:0] op, input logic [199:0] data, input int done_t,
                        input int hold, input bit keep_valid);
    logic [199:0] ma, mb, prod;
    logic         povf;
    bit           got;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = keep_valid;
    cmd_op    = 3'($urandom);
    cmd_data  = rnd200();
    exp_ready = 1'b0;
    exp_busy  = 1'b1;
    exp_rd    = '0;
    exp_ro    = 1'b0;
    exp_re    = 1'b0;
    if (op == 3'd3 || op == 3'd4) begin
      ma = m_a;
      mb = (op == 3'd4) ? m_a : m_b;
      mmul(ma, mb, prod, povf);
      exp_ma    = ma;
      exp_mb    = mb;
      exp_mact  = 1'b1;
      exp_start = 1'b1;
      @(posedge clk); #1;
      exp_start = 1'b0;
      got = 1'b0;
      for (int t = 0; t < TO; t++) begin
        rsp_ready = 1'($urandom);
        if (t == done_t) begin
          mul_done     = 1'b1;
          mul_result   = prod;
          mul_overflow = povf;
        end
        @(posedge clk); #1;
        mul_done     = 1'b0;
        mul_result   = rnd200();
        mul_overflow = 1'($urandom);
        if (t == done_t) begin
          got = 1'b1;
          break;
        end
      end
      rsp_ready = 1'b0;
      exp_mact  = 1'b0;
      if (got) begin
        m_r      = prod;
        m_rovf   = povf;
        m_sticky = m_sticky | povf;
        exp_rd   = prod;
        exp_ro   = povf;
      end else begin
        exp_re = 1'b1;
      end
    end else begin
      case (op)
        3'd1: m_a = data;
        3'd2: m_b = data;
        3'd5: begin exp_rd = m_r; exp_ro = m_rovf; end
        3'd6: begin m_sticky = 1'b0; m_rovf = 1'b0; end
        3'd7: exp_re = 1'b1;
        default: ;
      endcase
    end
    exp_rv = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (keep_valid) begin
        cmd_op   = 3'($urandom);
        cmd_data = rnd200();
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    exp_rv    = 1'b0;
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    rsp_ready = 1'b0; mul_done = 1'b0; mul_result = '0; mul_overflow = 1'b0;
    exp_ma = '0; exp_mb = '0;
    last_data = '0; last_ovf = 1'b0; last_err = 1'b0;
    id_m = '0;
    for (int i = 0; i < 5; i++) id_m[(i*6)*8 +: 8] = 8'd1;
    all3   = {25{8'd3}};
    all20  = {25{8'd20}};
    all127 = {25{8'h7f}};

    #1 do_reset(1'b1);
    do_cmd(3'd5, rnd200(), -1, 0, 1'b0);
    chk("r_after_reset", last_data, '0);

    // Identity times all-3s, done 29 cycles after mul_start.
    do_cmd(3'd1, id_m, -1, 0, 1'b0);
    do_cmd(3'd2, all3, -1, 0, 1'b0);
    do_cmd(3'd3, rnd200(), 28, 0, 1'b0);
    chk("mul_id_3", last_data, all3);
    chk_b("mul_id_ovf", last_ovf, 1'b0);
    chk_b("mul_id_err", last_err, 1'b0);
    do_cmd(3'd5, rnd200(), -1, 0, 1'b0);
    chk("read_after_mul", last_data, all3);

    // Square of all-20s saturates; sticky set, then cleared by CLR.
    do_cmd(3'd1, all20, -1, 0, 1'b0);
    do_cmd(3'd4, rnd200(), 10, 0, 1'b0);
    chk("sqr_data", last_data, all127);
    chk_b("sqr_ovf", last_ovf, 1'b1);
    chk_b("sqr_sticky", ovf_sticky, 1'b1);
    do_cmd(3'd6, rnd200(), -1, 0, 1'b0);
    chk_b("clr_sticky", ovf_sticky, 1'b0);
    do_cmd(3'd5, rnd200(), -1, 0, 1'b0);
    chk_b("read_after_clr_ovf", last_ovf, 1'b0);
    chk("read_after_clr_data", last_data, all127);

    // Timeout, then a late done that must be ignored.
    do_cmd(3'd3, rnd200(), -1, 0, 1'b0);
    chk_b("timeout_err", last_err, 1'b1);
    chk("timeout_data", last_data, '0);
    mul_done = 1'b1; mul_result = rnd200(); mul_overflow = 1'b1;
    @(posedge clk); #1;
    mul_done = 1'b0; mul_overflow = 1'b0;
    do_cmd(3'd5, rnd200(), -1, 0, 1'b0);
    chk("r_kept_after_timeout", last_data, all127);
    chk_b("r_ovf_after_timeout", last_ovf, 1'b0);

    // Done in the final WAIT cycle beats the timeout; one cycle later does not.
    do_cmd(3'd2, small200(), -1, 0, 1'b0);
    do_cmd(3'd3, rnd200(), TO - 1, 0, 1'b0);
    chk_b("done_at_limit_err", last_err, 1'b0);
    do_cmd(3'd3, rnd200(), TO, 0, 1'b0);
    chk_b("done_past_limit_err", last_err, 1'b1);

    // Host stall with cmd_valid held, then back-to-back bad opcode.
    do_cmd(3'd2, rnd200(), -1, 10, 1'b1);
    do_cmd(3'd7, rnd200(), -1, 0, 1'b0);
    chk_b("bad_op_err", last_err, 1'b1);
    do_cmd(3'd5, rnd200(), -1, 0, 1'b0);

    // Reset while waiting on the multiplier.
    do_cmd(3'd1, all20, -1, 0, 1'b0);
    do_cmd(3'd4, rnd200(), 5, 0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 3'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_ready = 1'b0; exp_busy = 1'b1; exp_start = 1'b1;
    exp_mact = 1'b1; exp_ma = m_a; exp_mb = m_b;
    @(posedge clk); #1;
    exp_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 do_reset(1'b1);
    do_cmd(3'd5, rnd200(), -1, 0, 1'b0);
    chk("r_after_wait_reset", last_data, '0);

    // Randomized command stream.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_cmd(op, ($urandom % 2 == 0) ? small200() : rnd200(),
             int'($urandom_range(0, 70)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
